// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
// -----------------------------------------------------------------------------
// Purpose:
//   N-channel arbitrating mux with valid/ready handshakes on every requester
//   and one registered output stage. Several requesters (CPU, DMA, PPU fetch)
//   share one downstream bus port, and at most one word is forwarded per cycle.
//   The input uses the same flat packed layout as the plain combinational mux:
//   channel i occupies in[i*width +: width].
//
// Configuration macro:
//   RR_ARB_MUX_FIXED_PRIO_EN
//     defined   : fixed priority, the lowest index wins. There is no rotating
//                 pointer, so high indices can starve.
//     undefined : round-robin. This is the default build.
//   The output stage, handshake, latency and reset are the same in both builds.
//
// Parameters:
//   width    : data bits per channel
//   channels : number of requesters (>= 2; need not be a power of two)
//
// Ports:
//   clock     in   1               rising-edge clock
//   reset_n   in   1               asynchronous active-low reset
//   in        in   width*channels  packed request data
//   in_valid  in   channels        per-channel request
//   in_ready  out  channels        per-channel accept (one-hot or zero)
//   out       out  width           registered data
//   out_sel   out  SELW            channel index that supplied out
//   out_valid out  1               out holds a word
//   out_ready in   1               downstream accept
//
// Notes:
//   in_ready depends combinationally on in_valid, out_valid, out_ready and
//   reset_n. It never depends on the in data. A requester must not derive
//   in_valid from in_ready, because that would form a combinational loop.
//   Requesters hold in_valid and data until they are accepted; the block
//   does not check this.
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int width    = 8,
    parameter int channels = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [width*channels-1:0]   in,
    input  logic [channels-1:0]         in_valid,
    output logic [channels-1:0]         in_ready,
    output logic [width-1:0]            out,
    output logic [$clog2(channels)-1:0] out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int SELW = $clog2(channels);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [width-1:0]   out_r;
    logic [SELW-1:0]    out_sel_r;
    logic               out_valid_r;

    logic [SELW-1:0]    base_s;        // index where the grant search starts
    logic               load_s;        // output stage can take a word this cycle
    logic               grant_vld_s;
    logic [SELW-1:0]    grant_idx_s;
    logic [width-1:0]   grant_data_s;
    logic [channels-1:0] in_ready_s;
    logic               transfer_s;

    // Returns (base + offs) modulo channels. Because it wraps at channels and
    // not at 2**SELW, a non-power-of-two channel count never yields an index
    // past the last channel.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= channels) begin
            sum = sum - channels;
        end else begin
            sum = sum;
        end
        return SELW'(sum);
    endfunction

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: the search always starts at channel 0.
    assign base_s = {SELW{1'b0}};
`else
    logic [SELW-1:0] rr_ptr_r;

    // The channel after the one just granted, wrapping the last channel to 0.
    function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] g);
        logic [SELW-1:0] nxt;
        if (int'(g) == channels - 1) begin
            nxt = {SELW{1'b0}};
        end else begin
            nxt = g + {{(SELW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Round-robin pointer: it advances past the granted channel, but only on
    // an actual transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {SELW{1'b0}};
        end else if (transfer_s) begin
            rr_ptr_r <= next_ptr(grant_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign base_s = rr_ptr_r;
`endif

    // The stage accepts a word when it is empty, or when its current word
    // drains in the same cycle.
    assign load_s = ~out_valid_r | out_ready;

    // Grant search: the first requesting channel, scanning upward from base_s
    // with wrap-around.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {SELW{1'b0}};
        for (int k = 0; k < channels; k++) begin
            if (!grant_vld_s && in_valid[wrap_add(base_s, k)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = wrap_add(base_s, k);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot accept and AND-OR data select. in_ready is held low while in
    // reset and while the stage is stalled.
    always_comb begin
        in_ready_s   = {channels{1'b0}};
        grant_data_s = {width{1'b0}};
        for (int i = 0; i < channels; i++) begin
            in_ready_s[i] = grant_vld_s & (grant_idx_s == SELW'(i)) & load_s & reset_n;
            grant_data_s  = grant_data_s
                          | ({width{grant_idx_s == SELW'(i)}} & in[i*width +: width]);
        end
    end

    assign transfer_s = grant_vld_s & load_s;

    // Output stage FSM: EMPTY/FULL with registered data, select and valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            out_r       <= {width{1'b0}};
            out_sel_r   <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (grant_vld_s) begin
                        state_r     <= ST_FULL;
                        out_r       <= grant_data_s;
                        out_sel_r   <= grant_idx_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_ready && grant_vld_s) begin
                        // The old word drains and the new one loads in the same cycle.
                        state_r     <= ST_FULL;
                        out_r       <= grant_data_s;
                        out_sel_r   <= grant_idx_s;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        // Stalled: the held word stays stable.
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_r       <= {width{1'b0}};
                    out_sel_r   <= {SELW{1'b0}};
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out       = out_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux. It uses a 4-channel and a 3-channel
// instance with width=4. Inputs change shortly after the rising edge, and
// outputs are sampled 1 time unit after it.
module tb_rr_arb_mux;

    logic        clock;
    logic        reset_n;

    logic [15:0] in;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] in3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int pass_cnt;
    int chk_cnt;

    rr_arb_mux #(.width(4), .channels(4)) dut (
        .clock(clock), .reset_n(reset_n), .in(in), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_arb_mux #(.width(4), .channels(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .in(in3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out(out3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 4'b0000;
        in_valid3 = 3'b000;
        reset_n   = 1'b0;
        #2;
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in        = 16'h1234;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out !== 4'h0) $display("FAIL reset_out got %0h want 0", out); else pass_cnt++;
        chk_cnt++; if (out_sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", out_sel); else pass_cnt++;
        chk_cnt++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", in_ready); else pass_cnt++;
        reset_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 4'b0001) $display("FAIL release_in_ready got %b want 0001", in_ready); else pass_cnt++;
        in_valid = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        in        = 16'h1234;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 4'b0001) $display("FAIL single_in_ready got %b want 0001", in_ready); else pass_cnt++;
        tick();
        in_valid = 4'b0000;
        chk_cnt++; if (out !== 4'h4) $display("FAIL single_out got %0h want 4", out); else pass_cnt++;
        chk_cnt++; if (out_sel !== 2'd0) $display("FAIL single_sel got %0d want 0", out_sel); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", out_valid); else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_out [5] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
        logic [3:0] exp_rdy;
        do_reset();
        in        = 16'h1234;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_rdy = 4'b0001 << exp_sel[i];
            #1;
            chk_cnt++; if (in_ready !== exp_rdy) $display("FAIL rot_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy); else pass_cnt++;
            tick();
            chk_cnt++; if (out_sel !== exp_sel[i]) $display("FAIL rot_sel[%0d] got %0d want %0d", i, out_sel, exp_sel[i]); else pass_cnt++;
            chk_cnt++; if (out !== exp_out[i]) $display("FAIL rot_out[%0d] got %0h want %0h", i, out, exp_out[i]); else pass_cnt++;
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        in        = 16'h1234;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if (in_ready !== 4'b0000) $display("FAIL stall_in_ready[%0d] got %b want 0000", i, in_ready); else pass_cnt++;
            tick();
            chk_cnt++; if (out !== 4'h4 || out_sel !== 2'd0 || out_valid !== 1'b1)
                $display("FAIL stall_hold[%0d] got out=%0h sel=%0d v=%0b want 4/0/1", i, out, out_sel, out_valid); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 4'b0010) $display("FAIL resume_in_ready got %b want 0010", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (out !== 4'h3 || out_sel !== 2'd1) $display("FAIL resume_word got out=%0h sel=%0d want 3/1", out, out_sel); else pass_cnt++;
        // Drain with no requester: the stage goes EMPTY.
        in_valid = 4'b0000;
        #1;
        chk_cnt++; if (in_ready !== 4'b0000) $display("FAIL idle_in_ready got %b want 0000", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %0b want 0", out_valid); else pass_cnt++;
        // An EMPTY stage accepts even with out_ready low; the pointer is now 2.
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        #1;
        chk_cnt++; if (in_ready !== 4'b0100) $display("FAIL empty_accept_in_ready got %b want 0100", in_ready); else pass_cnt++;
        tick();
        in_valid = 4'b0000;
        chk_cnt++; if (out !== 4'h2 || out_sel !== 2'd2 || out_valid !== 1'b1)
            $display("FAIL empty_accept_word got out=%0h sel=%0d v=%0b want 2/2/1", out, out_sel, out_valid); else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_wrap3();
        do_reset();
        in3        = 12'h321;
        in_valid3  = 3'b100;
        out_ready3 = 1'b1;
        #1;
        chk_cnt++; if (in_ready3 !== 3'b100) $display("FAIL wrap_in_ready0 got %b want 100", in_ready3); else pass_cnt++;
        tick();
        chk_cnt++; if (out_sel3 !== 2'd2 || out3 !== 4'h3) $display("FAIL wrap_first got sel=%0d out=%0h want 2/3", out_sel3, out3); else pass_cnt++;
        #1;
        chk_cnt++; if (in_ready3 !== 3'b100) $display("FAIL wrap_in_ready1 got %b want 100", in_ready3); else pass_cnt++;
        tick();
        chk_cnt++; if (out_sel3 !== 2'd2 || out_valid3 !== 1'b1) $display("FAIL wrap_again got sel=%0d v=%0b want 2/1", out_sel3, out_valid3); else pass_cnt++;
        // The pointer wrapped to 0, so channel 0 wins next.
        in_valid3 = 3'b111;
        #1;
        chk_cnt++; if (in_ready3 !== 3'b001) $display("FAIL wrap_ptr0_in_ready got %b want 001", in_ready3); else pass_cnt++;
        tick();
        chk_cnt++; if (out_sel3 !== 2'd0 || out3 !== 4'h1) $display("FAIL wrap_ptr0_word got sel=%0d out=%0h want 0/1", out_sel3, out3); else pass_cnt++;
        in_valid3 = 3'b000;
    endtask

    task automatic test_async_reset();
        do_reset();
        in        = 16'h1234;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        chk_cnt++; if (out_valid !== 1'b1 || out_sel !== 2'd1) $display("FAIL pre_reset got v=%0b sel=%0d want 1/1", out_valid, out_sel); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || out !== 4'h0 || out_sel !== 2'd0)
            $display("FAIL async_reset got v=%0b out=%0h sel=%0d want 0/0/0", out_valid, out, out_sel); else pass_cnt++;
        reset_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 4'b0001) $display("FAIL post_reset_in_ready got %b want 0001", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (out_sel !== 2'd0 || out !== 4'h4) $display("FAIL post_reset_word got sel=%0d out=%0h want 0/4", out_sel, out); else pass_cnt++;
        in_valid = 4'b0000;
    endtask

    // Channels 1 and 3 request continuously. Fixed priority always picks 1;
    // round-robin alternates 1 and 3.
    task automatic test_prio_1010();
        logic [1:0] exp_sel;
        logic [3:0] exp_out;
        logic [3:0] exp_rdy;
        do_reset();
        in        = 16'h1234;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
            exp_sel = 2'd1;
`else
            exp_sel = (i % 2 == 0) ? 2'd1 : 2'd3;
`endif
            exp_out = (exp_sel == 2'd1) ? 4'h3 : 4'h1;
            exp_rdy = 4'b0001 << exp_sel;
            #1;
            chk_cnt++; if (in_ready !== exp_rdy) $display("FAIL prio_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy); else pass_cnt++;
            tick();
            chk_cnt++; if (out_sel !== exp_sel || out !== exp_out)
                $display("FAIL prio_word[%0d] got sel=%0d out=%0h want %0d/%0h", i, out_sel, out, exp_sel, exp_out); else pass_cnt++;
        end
        in_valid = 4'b0000;
    endtask

    initial begin
        pass_cnt   = 0;
        chk_cnt    = 0;
        reset_n    = 1'b0;
        in         = 16'h0000;
        in_valid   = 4'b0000;
        out_ready  = 1'b1;
        in3        = 12'h000;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap3();
        test_async_reset();
        test_prio_1010();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
